// File: rtl/popcount_arbiter.sv
// Round-robin front end for one shared popcount engine.
// Level-held requests are granted in rotating order. The operand is captured
// and handed to the engine through a load/start handshake. The count comes
// back on a valid/ready response. A watchdog turns a stuck engine into an
// error response and a one-cycle engine reset.
module popcount_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_WIDTH  = 2,
    parameter int A_WIDTH   = 8,
    parameter int RES_WIDTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*A_WIDTH-1:0]   req_a,
    output logic [N_REQ-1:0]           req_ack,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_WIDTH-1:0]        resp_id,
    output logic [RES_WIDTH-1:0]       resp_result,
    output logic                       resp_err,
    output logic                       cnt_s,
    output logic [A_WIDTH-1:0]         cnt_a,
    output logic                       cnt_rst,
    input  logic                       cnt_done,
    input  logic [RES_WIDTH-1:0]       cnt_result
);

    // The watchdog must be able to hold TIMEOUT-1.
    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        RESP,
        CLEAR
    } state_t;

    state_t                          state;
    logic [ID_WIDTH-1:0]             grant_id;
    logic [ID_WIDTH-1:0]             rr_ptr;
    logic [A_WIDTH-1:0]              op_a;
    logic [WD_WIDTH-1:0]             wd_cnt;
    logic [RES_WIDTH-1:0]            res_q;
    logic                            err_q;

    logic [N_REQ-1:0][A_WIDTH-1:0]   operands;
    logic                            pick_found;
    logic [ID_WIDTH-1:0]             pick_id;
    logic [ID_WIDTH-1:0]             pick_next;
    logic [A_WIDTH-1:0]              pick_a;

    // Unpack the flat operand bus into one lane per requester.
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign operands[i] = req_a[i*A_WIDTH +: A_WIDTH];
    end

    // Round-robin pick: lowest requester at or above rr_ptr, otherwise the
    // lowest requester overall (the scan wraps). The loop runs downward so
    // the last hit written is the lowest index in each class.
    always_comb begin
        logic                hi_found;
        logic [ID_WIDTH-1:0] hi_id;
        logic [ID_WIDTH-1:0] lo_id;
        hi_found   = 1'b0;
        hi_id      = '0;
        lo_id      = '0;
        pick_found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_found = 1'b1;
                lo_id      = ID_WIDTH'(i);
                if (ID_WIDTH'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_id    = ID_WIDTH'(i);
                end
            end
        end
        pick_id   = hi_found ? hi_id : lo_id;
        pick_next = (pick_id == ID_WIDTH'(N_REQ - 1)) ? '0 : pick_id + ID_WIDTH'(1);
        pick_a    = operands[pick_id];
    end

    // Main controller. Every output is a register or a register-gated
    // decode, so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            rr_ptr     <= '0;
            op_a       <= '0;
            wd_cnt     <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            req_ack    <= '0;
            resp_valid <= 1'b0;
            cnt_s      <= 1'b0;
            cnt_rst    <= 1'b0;
        end else begin
            // Ack and engine reset are single-cycle pulses.
            req_ack <= '0;
            cnt_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        op_a     <= pick_a;
                        rr_ptr   <= pick_next;
                        req_ack  <= N_REQ'(1) << pick_id;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // The engine copies op_a this cycle because cnt_s is still low.
                    wd_cnt <= '0;
                    cnt_s  <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    // A done that arrives on the expiry cycle takes priority.
                    if (cnt_done) begin
                        res_q      <= cnt_result;
                        err_q      <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wd_cnt == WD_WIDTH'(TIMEOUT - 1)) begin
                        res_q      <= '0;
                        err_q      <= 1'b1;
                        resp_valid <= 1'b1;
                        cnt_s      <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + WD_WIDTH'(1);
                    end
                end
                RESP: begin
                    // cnt_s stays high here so a healthy engine keeps its result stable.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cnt_s      <= 1'b0;
                        cnt_rst    <= err_q;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    // Wait until done has fallen so the next grant sees a clean engine.
                    if (!cnt_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cnt_a       = op_a;
    assign resp_id     = resp_valid ? grant_id : '0;
    assign resp_result = resp_valid ? res_q    : '0;
    assign resp_err    = resp_valid & err_q;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter with a behavioural popcount engine.
module tb_popcount_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_a = '0;
    logic [3:0]  req_ack;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [1:0]  resp_id;
    logic [3:0]  resp_result;
    logic        resp_err;
    logic        cnt_s;
    logic [7:0]  cnt_a;
    logic        cnt_rst;
    logic        cnt_done;
    logic [3:0]  cnt_result;

    int n_checks = 0;
    int n_pass   = 0;

    // Engine knobs, set by the stimulus.
    int eng_lat  = 3;
    int eng_drop = 0;
    bit eng_hang = 1'b0;

    logic       eng_done;
    logic [3:0] eng_res;
    logic [7:0] eng_op;
    int         eng_cnt;
    int         drop_cnt;

    assign cnt_done   = eng_done;
    assign cnt_result = eng_res;

    popcount_arbiter #(
        .N_REQ(4), .ID_WIDTH(2), .A_WIDTH(8), .RES_WIDTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_err(resp_err), .cnt_s(cnt_s),
        .cnt_a(cnt_a), .cnt_rst(cnt_rst), .cnt_done(cnt_done), .cnt_result(cnt_result)
    );

    always #5 clk = ~clk;

    // Engine: loads while idle, counts for eng_lat cycles under cnt_s, holds
    // done while cnt_s is high, then drops done eng_drop cycles after cnt_s falls.
    always @(posedge clk) begin
        if (reset || cnt_rst) begin
            eng_done <= 1'b0;
            eng_res  <= '0;
            eng_op   <= '0;
            eng_cnt  <= 0;
            drop_cnt <= 0;
        end else if (!cnt_s) begin
            if (eng_done) begin
                if (drop_cnt >= eng_drop) begin
                    eng_done <= 1'b0;
                    drop_cnt <= 0;
                end else begin
                    drop_cnt <= drop_cnt + 1;
                end
            end else begin
                eng_op  <= cnt_a;
                eng_cnt <= 0;
            end
        end else if (!eng_done && !eng_hang) begin
            if (eng_cnt == eng_lat - 1) begin
                eng_done <= 1'b1;
                eng_res  <= 4'($countones(eng_op));
            end
            eng_cnt <= eng_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Advance until resp_valid; cyc is the edge count, or -1 if the bound expires.
    task automatic wait_resp(input bit drop, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
            if (drop && req_ack != 4'b0) req = req & ~req_ack;
        end while (!resp_valid && cyc < 200);
        if (!resp_valid) cyc = -1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (req_ack !== 4'b0) $display("FAIL reset_req_ack: got %b want 0000", req_ack); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_id !== 2'd0) $display("FAIL reset_resp_id: got %0d want 0", resp_id); else n_pass++;
        n_checks++; if (resp_result !== 4'd0) $display("FAIL reset_resp_result: got %0d want 0", resp_result); else n_pass++;
        n_checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err); else n_pass++;
        n_checks++; if (cnt_s !== 1'b0) $display("FAIL reset_cnt_s: got %b want 0", cnt_s); else n_pass++;
        n_checks++; if (cnt_a !== 8'h00) $display("FAIL reset_cnt_a: got %h want 00", cnt_a); else n_pass++;
        n_checks++; if (cnt_rst !== 1'b0) $display("FAIL reset_cnt_rst: got %b want 0", cnt_rst); else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        req_a[7:0] = 8'b1010_1010;
        req = 4'b0001;
        tick();
        n_checks++; if (req_ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", req_ack); else n_pass++;
        n_checks++; if (cnt_s !== 1'b0) $display("FAIL single_load_cnt_s: got %b want 0", cnt_s); else n_pass++;
        n_checks++; if (cnt_a !== 8'hAA) $display("FAIL single_cnt_a: got %h want aa", cnt_a); else n_pass++;
        req = 4'b0000;
        tick();
        n_checks++; if (req_ack !== 4'b0000) $display("FAIL single_ack_pulse: got %b want 0000", req_ack); else n_pass++;
        n_checks++; if (cnt_s !== 1'b1) $display("FAIL single_run_cnt_s: got %b want 1", cnt_s); else n_pass++;
        // Latency 3 engine: done after 3 counting edges, RESP one edge later.
        wait_resp(1'b0, cyc);
        n_checks++; if (cyc !== 4) $display("FAIL single_latency: got %0d want 4", cyc); else n_pass++;
        n_checks++; if (resp_id !== 2'd0) $display("FAIL single_id: got %0d want 0", resp_id); else n_pass++;
        n_checks++; if (resp_result !== 4'd4) $display("FAIL single_result: got %0d want 4", resp_result); else n_pass++;
        n_checks++; if (resp_err !== 1'b0) $display("FAIL single_err: got %b want 0", resp_err); else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL single_accept: got %b want 0", resp_valid); else n_pass++;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        int         cyc;
        logic [1:0] exp_id [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_res [5] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd1};
        do_reset();
        req_a = {8'hFF, 8'h07, 8'h03, 8'h01};
        req = 4'b1111;
        resp_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            wait_resp(1'b0, cyc);
            n_checks++; if (cyc < 0) $display("FAIL rr_timeout[%0d]: got no response want response", r); else n_pass++;
            n_checks++; if (resp_id !== exp_id[r]) $display("FAIL rr_id[%0d]: got %0d want %0d", r, resp_id, exp_id[r]); else n_pass++;
            n_checks++; if (resp_result !== exp_res[r]) $display("FAIL rr_result[%0d]: got %0d want %0d", r, resp_result, exp_res[r]); else n_pass++;
        end
        req = 4'b0000;
        tick();
        resp_ready = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int cyc;
        req_a[15:8] = 8'b1011_0110;
        req = 4'b0010;
        wait_resp(1'b1, cyc);
        n_checks++; if (cyc < 0) $display("FAIL bp_timeout: got no response want response"); else n_pass++;
        n_checks++; if (resp_id !== 2'd1) $display("FAIL bp_id: got %0d want 1", resp_id); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", k, resp_valid); else n_pass++;
            n_checks++; if (resp_result !== 4'd5) $display("FAIL bp_result[%0d]: got %0d want 5", k, resp_result); else n_pass++;
            n_checks++; if (cnt_s !== 1'b1) $display("FAIL bp_cnt_s[%0d]: got %b want 1", k, cnt_s); else n_pass++;
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp_accept: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (cnt_s !== 1'b0) $display("FAIL bp_clear_cnt_s: got %b want 0", cnt_s); else n_pass++;
        n_checks++; if (cnt_rst !== 1'b0) $display("FAIL bp_no_cnt_rst: got %b want 0", cnt_rst); else n_pass++;
        tick();
        tick();
        tick();
    endtask

    task automatic test_zero_operand();
        int cyc;
        eng_drop = 1;
        req_a[23:16] = 8'h00;
        req = 4'b0100;
        wait_resp(1'b1, cyc);
        n_checks++; if (resp_id !== 2'd2) $display("FAIL zero_id: got %0d want 2", resp_id); else n_pass++;
        n_checks++; if (resp_result !== 4'd0) $display("FAIL zero_result: got %0d want 0", resp_result); else n_pass++;
        n_checks++; if (resp_err !== 1'b0) $display("FAIL zero_err: got %b want 0", resp_err); else n_pass++;
        // Next requester waits while CLEAR holds for the slow done release.
        req_a[31:24] = 8'h0F;
        req = 4'b1000;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();
        n_checks++; if (cnt_done !== 1'b1) $display("FAIL zero_done_held: got %b want 1", cnt_done); else n_pass++;
        for (int k = 2; k <= 3; k++) begin
            n_checks++; if (req_ack !== 4'b0000) $display("FAIL zero_clear_ack[%0d]: got %b want 0000", k, req_ack); else n_pass++;
            n_checks++; if (cnt_s !== 1'b0) $display("FAIL zero_clear_cnt_s[%0d]: got %b want 0", k, cnt_s); else n_pass++;
            tick();
        end
        tick();
        n_checks++; if (req_ack !== 4'b1000) $display("FAIL zero_next_ack: got %b want 1000", req_ack); else n_pass++;
        req = 4'b0000;
        wait_resp(1'b0, cyc);
        n_checks++; if (resp_id !== 2'd3) $display("FAIL zero_next_id: got %0d want 3", resp_id); else n_pass++;
        n_checks++; if (resp_result !== 4'd4) $display("FAIL zero_next_result: got %0d want 4", resp_result); else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        eng_drop = 0;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int cyc;
        int pulses;
        eng_hang = 1'b1;
        req_a[7:0] = 8'h55;
        req = 4'b0001;
        tick();
        n_checks++; if (req_ack !== 4'b0001) $display("FAIL to_ack: got %b want 0001", req_ack); else n_pass++;
        req = 4'b0000;
        // One edge into RUN, then 16 RUN cycles before the watchdog fires.
        wait_resp(1'b0, cyc);
        n_checks++; if (cyc !== 17) $display("FAIL to_latency: got %0d want 17", cyc); else n_pass++;
        n_checks++; if (resp_err !== 1'b1) $display("FAIL to_err: got %b want 1", resp_err); else n_pass++;
        n_checks++; if (resp_result !== 4'd0) $display("FAIL to_result: got %0d want 0", resp_result); else n_pass++;
        n_checks++; if (cnt_s !== 1'b0) $display("FAIL to_cnt_s: got %b want 0", cnt_s); else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_checks++; if (cnt_rst !== 1'b1) $display("FAIL to_cnt_rst: got %b want 1", cnt_rst); else n_pass++;
        pulses = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (cnt_rst) pulses++;
        end
        n_checks++; if (pulses !== 1) $display("FAIL to_cnt_rst_pulses: got %0d want 1", pulses); else n_pass++;
        eng_hang = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        eng_lat = 10;
        req_a[15:8] = 8'h03;
        req = 4'b0010;
        tick();
        n_checks++; if (req_ack !== 4'b0010) $display("FAIL rst_run_ack: got %b want 0010", req_ack); else n_pass++;
        req = 4'b0011;
        tick();
        tick();
        n_checks++; if (cnt_s !== 1'b1) $display("FAIL rst_run_cnt_s: got %b want 1", cnt_s); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({req_ack, resp_valid, resp_id, resp_result, resp_err, cnt_s, cnt_a, cnt_rst} !== 21'd0)
            $display("FAIL rst_run_outputs: got ack=%b v=%b id=%0d res=%0d err=%b s=%b a=%h rst=%b want all 0",
                     req_ack, resp_valid, resp_id, resp_result, resp_err, cnt_s, cnt_a, cnt_rst);
        else n_pass++;
        tick();
        n_checks++; if (req_ack !== 4'b0001) $display("FAIL rst_run_next_grant: got %b want 0001", req_ack); else n_pass++;
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_run_no_resp[%0d]: got %b want 0", k, resp_valid); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_zero_operand();
        test_timeout();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
